// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the serial-debug printers.
package debug_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_a  = 8'h61;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational hex digit to ASCII character.
module nibble_to_ascii
    import debug_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    localparam logic [7:0] ALPHA = UPPERCASE ? ASCII_A : ASCII_a;

    always_comb begin
        unique case (1'b1)
            (nibble < 4'd10): ascii = ASCII_0 + {4'h0, nibble};
            default:          ascii = ALPHA + {4'h0, nibble} - 8'd10;
        endcase
    end

endmodule

// File: rtl/hex_word_tx.sv
// Prints one word as ASCII hex (MSN first, optional CR LF)
// through a start/data/ready UART byte interface.
module hex_word_tx
    import debug_pkg::*;
#(
    parameter int NIBBLES   = 8,
    parameter bit SEND_CRLF = 1'b1,
    parameter bit UPPERCASE = 1'b1,
    parameter int BUSY_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 busy
);

    localparam int W    = 4 * NIBBLES;
    localparam int IW   = $clog2(NIBBLES + 2);
    localparam int TW   = $clog2(BUSY_WAIT + 1);
    localparam int LAST = SEND_CRLF ? NIBBLES + 1 : NIBBLES - 1;

    typedef logic [IW-1:0] idx_t;

    localparam idx_t LAST_I = idx_t'(LAST);
    localparam logic [TW-1:0] TMO_END = TW'(BUSY_WAIT - 1);

    state_t        state;
    logic [W-1:0]  word_r;
    idx_t          idx;
    logic [TW-1:0] tmo;

    logic [W-1:0] src_word;
    idx_t         src_idx;
    logic [3:0]   nib;
    logic [7:0]   hex_c;
    logic [7:0]   next_c;

    // The next character is prepared ahead so tx_data is stable all of SEND.
    always_comb begin
        src_word = (state == IDLE) ? in_data : word_r;
        src_idx  = (state == IDLE) ? '0 : idx + idx_t'(1);
        nib      = '0;
        if (int'(src_idx) < NIBBLES)
            nib = 4'(src_word >> (4 * (NIBBLES - 1 - int'(src_idx))));
        next_c = hex_c;
        if (SEND_CRLF && int'(src_idx) == NIBBLES)
            next_c = ASCII_CR;
        if (SEND_CRLF && int'(src_idx) == NIBBLES + 1)
            next_c = ASCII_LF;
    end

    nibble_to_ascii #(
        .UPPERCASE(UPPERCASE)
    ) u_n2a (
        .nibble(nib),
        .ascii (hex_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_r   <= '0;
            idx      <= '0;
            tmo      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        word_r   <= in_data;
                        idx      <= '0;
                        tx_data  <= next_c;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        tmo      <= '0;
                        state    <= WAIT_BUSY;
                    end
                end
                // Timeout covers a transmitter that never drops ready.
                WAIT_BUSY: begin
                    if (!tx_ready || tmo == TMO_END)
                        state <= WAIT_DONE;
                    else
                        tmo <= tmo + 1'b1;
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        if (idx == LAST_I) begin
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx     <= idx + idx_t'(1);
                            tx_data <= next_c;
                            state   <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_word_tx.sv
// Bench for hex_word_tx: three configurations, UART ready model, byte scoreboard.
module tb_hex_word_tx;

    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid [3];
    logic [31:0] din      [3];
    logic        in_ready [3];
    logic        tx_start [3];
    logic [7:0]  tx_data  [3];
    logic        tx_ready [3];
    logic        busy     [3];

    int          mode [3];
    int          tc   [3];
    int          viol [3];
    logic        prev_start [3];
    int          cyc = 0;
    logic [7:0]  cap   [3][$];
    logic [7:0]  exp_q [3][$];
    int          st    [3][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hex_word_tx #(.NIBBLES(8), .SEND_CRLF(1'b1), .UPPERCASE(1'b1), .BUSY_WAIT(BW)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(din[0]),
        .in_ready(in_ready[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .tx_ready(tx_ready[0]), .busy(busy[0]));

    hex_word_tx #(.NIBBLES(8), .SEND_CRLF(1'b1), .UPPERCASE(1'b0), .BUSY_WAIT(BW)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(din[1]),
        .in_ready(in_ready[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .tx_ready(tx_ready[1]), .busy(busy[1]));

    hex_word_tx #(.NIBBLES(2), .SEND_CRLF(1'b0), .UPPERCASE(1'b1), .BUSY_WAIT(BW)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_data(din[2][7:0]),
        .in_ready(in_ready[2]), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
        .tx_ready(tx_ready[2]), .busy(busy[2]));

    // UART model: mode 0 drops ready 2 cycles after start for 20 cycles,
    // mode 1 never drops ready, mode 2 holds ready low.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tx_ready[i] = 1'b1;
            if (mode[i] == 2)
                tx_ready[i] = 1'b0;
            else if (mode[i] == 0 && tc[i] >= 2 && tc[i] < 22)
                tx_ready[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            int v;
            v = 0;
            if (tx_start[i]) begin
                cap[i].push_back(tx_data[i]);
                st[i].push_back(cyc);
                if (!tx_ready[i]) v++;
                if (prev_start[i]) v++;
            end
            if (busy[i] && in_ready[i]) v++;
            viol[i] <= viol[i] + v;
            prev_start[i] <= tx_start[i];
            if (tx_start[i])
                tc[i] <= 1;
            else if (tc[i] != 0)
                tc[i] <= (tc[i] >= 22) ? 0 : tc[i] + 1;
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int nib_of(int i);
        return (i == 2) ? 2 : 8;
    endfunction

    // Reference: hex text of the word, then CR LF where configured.
    task automatic add_exp(input int i, input logic [31:0] w);
        int n;
        int d;
        logic [7:0] alpha;
        n = nib_of(i);
        alpha = (i == 1) ? 8'h61 : 8'h41;
        for (int k = 0; k < n; k++) begin
            d = int'((w >> (4 * (n - 1 - k))) & 32'hF);
            if (d < 10) exp_q[i].push_back(8'(8'h30 + d));
            else        exp_q[i].push_back(8'(alpha + d - 10));
        end
        if (i != 2) begin
            exp_q[i].push_back(8'h0D);
            exp_q[i].push_back(8'h0A);
        end
    endtask

    task automatic clear(input int i);
        cap[i].delete();
        exp_q[i].delete();
        st[i].delete();
    endtask

    task automatic send(input int i, input logic [31:0] w);
        int n;
        n = 0;
        while (!in_ready[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("accept_wait", 64'(in_ready[i]), 64'd1);
        in_valid[i] = 1'b1;
        din[i] = w;
        add_exp(i, w);
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
        din[i] = $urandom;
    endtask

    task automatic wait_idle(input int i, input string tag);
        int n;
        n = 0;
        while ((busy[i] || !in_ready[i]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".idle"}, 64'(busy[i]), 64'd0);
    endtask

    task automatic check_bytes(input int i, input string tag);
        logic [7:0] a;
        chk({tag, ".len"}, 64'(cap[i].size()), 64'(exp_q[i].size()));
        for (int k = 0; k < exp_q[i].size(); k++) begin
            a = (k < cap[i].size()) ? cap[i][k] : 8'hxx;
            chk($sformatf("%s[%0d]", tag, k), 64'(a), 64'(exp_q[i][k]));
        end
        chk({tag, ".proto"}, 64'(viol[i]), 64'd0);
    endtask

    initial begin
        logic [7:0] dead [10];
        int n;
        int bad;
        int gap;
        dead = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42,
                 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            din[i] = '0;
            mode[i] = 0;
            tc[i] = 0;
            viol[i] = 0;
            prev_start[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst.in_ready%0d", i), 64'(in_ready[i]), 64'd1);
            chk($sformatf("rst.busy%0d", i), 64'(busy[i]), 64'd0);
            chk($sformatf("rst.tx_start%0d", i), 64'(tx_start[i]), 64'd0);
            chk($sformatf("rst.tx_data%0d", i), 64'(tx_data[i]), 64'h00);
        end

        send(0, 32'hDEADBEEF);
        wait_idle(0, "deadbeef");
        check_bytes(0, "deadbeef");
        for (int k = 0; k < 10; k++)
            chk($sformatf("deadbeef.lit[%0d]", k),
                64'((k < cap[0].size()) ? cap[0][k] : 8'hxx), 64'(dead[k]));

        send(1, 32'h89ABCDEF);
        wait_idle(1, "lower");
        check_bytes(1, "lower");

        send(2, 32'h000000A5);
        wait_idle(2, "n2");
        check_bytes(2, "n2");

        clear(0);
        add_exp(0, 32'h00000000);
        add_exp(0, 32'hFFFFFFFF);
        in_valid[0] = 1'b1;
        din[0] = 32'h00000000;
        @(posedge clk);
        @(negedge clk);
        din[0] = 32'hFFFFFFFF;
        chk("b2b.ready_drop", 64'(in_ready[0]), 64'd0);
        n = 0;
        while (!in_ready[0] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b.first_done", 64'(cap[0].size()), 64'd10);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_idle(0, "b2b");
        check_bytes(0, "b2b");

        clear(0);
        mode[0] = 2;
        send(0, 32'hDEADBEEF);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_data[0] !== 8'h44) bad++;
        end
        chk("hold.no_start", 64'(cap[0].size()), 64'd0);
        chk("hold.data_stable", 64'(bad), 64'd0);
        mode[0] = 0;
        @(posedge clk);
        @(negedge clk);
        chk("hold.release_start", 64'(tx_start[0]), 64'd1);
        wait_idle(0, "hold");
        check_bytes(0, "hold");

        clear(0);
        send(0, 32'h12345678);
        n = 0;
        while (cap[0].size() < 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        in_valid[0] = 1'b1;
        din[0] = 32'hCAFE0000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid[0] = 1'b0;
        chk("midrst.tx_start", 64'(tx_start[0]), 64'd0);
        chk("midrst.in_ready", 64'(in_ready[0]), 64'd1);
        chk("midrst.busy", 64'(busy[0]), 64'd0);
        repeat (30) @(negedge clk);
        chk("midrst.partial", 64'(cap[0].size()), 64'd3);
        clear(0);
        send(0, 32'h0000000F);
        wait_idle(0, "after_rst");
        check_bytes(0, "after_rst");

        clear(0);
        mode[0] = 1;
        send(0, $urandom);
        wait_idle(0, "nodrop");
        check_bytes(0, "nodrop");
        for (int k = 1; k < st[0].size(); k++) begin
            gap = st[0][k] - st[0][k-1];
            chk($sformatf("nodrop.gap[%0d]", k), 64'(gap), 64'(BW + 2));
        end
        mode[0] = 0;

        for (int r = 0; r < 3; r++) begin
            clear(1);
            send(1, $urandom);
            wait_idle(1, "rnd1");
            check_bytes(1, "rnd1");
            clear(2);
            send(2, $urandom);
            wait_idle(2, "rnd2");
            check_bytes(2, "rnd2");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_word_tx.md
Name: hex_word_tx

Overview:
- Upstream feeder for the UART transmitter in the serial-debug path.
- Accepts one debug word per handshake and converts it to ASCII hexadecimal, most-significant nibble first.
- Optionally appends CR LF.
- Drives the transmitter's start/data/ready byte interface one character at a time.
- Lets any FPGA signal be printed on a terminal without a CPU.

Parameters:
- NIBBLES, 8: hex digits per word; input word width is 4*NIBBLES; legal range 1..16.
- SEND_CRLF, 1: when 1, send 0x0D then 0x0A after the last digit; when 0, send no terminator.
- UPPERCASE, 1: when 1, digits 10..15 map to 0x41..0x46 ('A'..'F'); when 0, they map to 0x61..0x66.
- BUSY_WAIT, 4: maximum cycles to wait for tx_ready to fall after a tx_start pulse.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  word available.
- in_data  in  4*NIBBLES  word to print.
- in_ready  out  1  block can accept a word.
- tx_start  out  1  one-cycle request to the UART transmitter.
- tx_data  out  8  ASCII byte for the UART transmitter.
- tx_ready  in  1  UART transmitter idle.
- busy  out  1  a word is being emitted.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset values: tx_start=0, tx_data=0x00, in_ready=1, busy=0, state=IDLE, char index=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into word_r, set idx=0, go to SEND. in_ready drops the next cycle.
  - SEND: tx_data presents char(idx). If tx_ready=1, assert tx_start for exactly this one registered cycle and go to WAIT_BUSY. If tx_ready=0, hold with tx_start=0.
  - WAIT_BUSY: tx_start=0; tx_data held stable. Leave for WAIT_DONE when tx_ready=0, or after BUSY_WAIT cycles elapse. The transmitter drops ready 2 cycles after start; the timeout prevents deadlock if the transmitter is reset.
  - WAIT_DONE: wait for tx_ready=1. Then, if idx==LAST, go to IDLE; otherwise idx<=idx+1 and go to SEND.
- Character map:
  - idx 0..NIBBLES-1 selects nibble word_r[4*(NIBBLES-1-idx) +: 4].
  - Nibble 0..9 maps to 0x30+n; 10..15 maps per UPPERCASE.
  - If SEND_CRLF=1: idx NIBBLES gives 0x0D and NIBBLES+1 gives 0x0A.
  - LAST = NIBBLES+1 if SEND_CRLF=1, else NIBBLES-1.
  - idx width is clog2(NIBBLES+2).
- Timing and flow:
  - Latency from the accept cycle to the first tx_start is 1 cycle, provided tx_ready=1.
  - tx_data is valid in the cycle tx_start=1 and held until the next SEND.
  - tx_start is never asserted while tx_ready=0, and never on two consecutive cycles.
  - busy = (state != IDLE).
  - Words are never dropped or overlapped: in_ready=0 for the whole emission.
  - in_data may change after acceptance with no effect.
  - A new word may be accepted in the cycle after returning to IDLE.
- Reset mid-word: the next cycle is IDLE with tx_start=0. The partially printed word is abandoned; no terminator is sent.
- rst has priority over all transitions, including a simultaneous accept.

Decomposition:
- Shared package debug_pkg holds:
  - ASCII constants: ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_0=0x30, ASCII_A=0x41, ASCII_a=0x61.
  - The 2-bit state encodings: IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3.
- One combinational sub-module, nibble_to_ascii (4-bit in, 8-bit out, UPPERCASE parameter), reused by future hex printers.
- The FSM, index counter and timeout counter stay in hex_word_tx.

Test Plan:
- Default parameters, transmitter model drops ready 2 cycles after start and stays busy for 20 cycles; send 0xDEADBEEF -> exactly 10 tx_start pulses with bytes 44 45 41 44 42 45 45 46 0D 0A; in_ready=0 throughout; back to IDLE after the final tx_ready rise.
- UPPERCASE=0, send 0x89ABCDEF -> bytes 38 39 61 62 63 64 65 66 0D 0A.
- NIBBLES=2, SEND_CRLF=0, send 0xA5 -> bytes 41 35 only; busy=0 after the second transfer completes.
- Two words back-to-back (0x00000000 then 0xFFFFFFFF, in_valid held high) -> the second word is accepted only after the first word's 0A completes; output is "00000000\r\nFFFFFFFF\r\n".
- Hold tx_ready=0 for 50 cycles after acceptance -> no tx_start and tx_data=0x44 stable; on release, the first start occurs the same cycle tx_ready is sampled high.
- Assert rst for 1 cycle after the third character of 0x12345678 -> next cycle IDLE, tx_start=0, in_ready=1; then send 0x0000000F -> full output "0000000F\r\n".
- Transmitter never drops ready -> each character advances after BUSY_WAIT=4 cycles; no hang.
